// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and RAM handshake state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

endpackage : cpu_types_pkg

// File: rtl/mem_arbiter_pkg.sv
// Local types for the icache/dcache memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_I = 2'b01,
    GRANT_D = 2'b10
  } arb_state_t;

  localparam logic [15:0] ERRCOUNT_MAX = 16'hFFFF;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side bus of the memory arbiter.
// slave: the arbiter's view. master: the caches + RAM that surround it.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  // icache side
  logic      iREN;
  word_t     iaddr;
  word_t     iload;
  logic      iwait;
  // dcache side
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  word_t     dload;
  logic      dwait;
  // RAM side
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface : mem_arbiter_if

// File: rtl/mem_arb_timer.sv
// Grant timeout counter: held at zero by clear, counts enabled cycles,
// flags expiry when it reaches TIMEOUT_CYCLES-1 and holds there.
module mem_arb_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] count;

  // Count grant cycles; stop at the expiry value so it can never wrap.
  always_ff @(posedge CLK) begin
    if (RST || clear)
      count <= '0;
    else if (enable && !expired)
      count <= count + CW'(1);
  end

  assign expired = (count == CW'(TIMEOUT_CYCLES - 1));

endmodule : mem_arb_timer

// File: rtl/mem_arbiter.sv
// Arbitrates icache fetches and dcache loads/stores onto one RAM port.
// Dcache wins ties unless the icache has been passed over MAX_DSTREAK times.
// RAM errors and timeouts abort the grant; the requester is re-arbitrated.
module mem_arbiter
  import cpu_types_pkg::*;
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_DSTREAK    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          CLK,
  input  logic          RST,
  mem_arbiter_if.slave  bus,
  output word_t         icount,
  output word_t         dcount,
  output logic [15:0]   errcount
);

  localparam int SW = $clog2(MAX_DSTREAK + 1);

  arb_state_t    state, next_state;
  logic [SW-1:0] streak;
  logic          d_req, i_held, d_held, is_access, is_error;
  logic          i_done, d_done, abort_err, expired;

  assign d_req     = bus.dREN | bus.dWEN;
  assign is_access = (bus.ramstate == ACCESS);
  assign is_error  = (bus.ramstate == ERROR);
  assign i_held    = (state == GRANT_I) && bus.iREN;
  assign d_held    = (state == GRANT_D) && d_req;
  assign i_done    = i_held && is_access;
  assign d_done    = d_held && is_access;
  assign abort_err = (i_held || d_held) && !is_access && (is_error || expired);

  mem_arb_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (state == IDLE),
    .enable  (state != IDLE),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state: pick a requester in IDLE, leave a grant on done/abort/drop.
  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state;
    unique case (state)
      IDLE: begin
        if (bus.iREN && (!d_req || streak == SW'(MAX_DSTREAK))) next_state = GRANT_I;
        else if (d_req)                                         next_state = GRANT_D;
      end
      GRANT_I: if (!bus.iREN || is_access || is_error || expired) next_state = IDLE;
      GRANT_D: if (!d_req    || is_access || is_error || expired) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs: RAM drive and cache handshake follow the granted requester combinationally.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.iload    = '0;
    bus.dload    = '0;
    unique case (state)
      GRANT_I: begin
        bus.ramREN  = bus.iREN;
        bus.ramaddr = bus.iaddr;
        bus.iwait   = !i_done;
        bus.iload   = i_done ? bus.ramload : '0;
      end
      GRANT_D: begin
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & !bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.dwait    = !d_done;
        bus.dload    = (d_done && !bus.dWEN) ? bus.ramload : '0;
      end
      default: ;
    endcase
  end

  // Dcache streak: counts dcache grants taken while the icache waits.
  always_ff @(posedge CLK) begin
    if (RST)
      streak <= '0;
    else if (state == IDLE) begin
      if (next_state == GRANT_I || !bus.iREN)
        streak <= '0;
      else if (next_state == GRANT_D && streak != SW'(MAX_DSTREAK))
        streak <= streak + SW'(1);
    end
  end

  // Statistics: completions wrap, aborts saturate.
  always_ff @(posedge CLK) begin
    if (RST) begin
      icount   <= '0;
      dcount   <= '0;
      errcount <= '0;
    end else begin
      if (i_done) icount <= icount + 32'd1;
      if (d_done) dcount <= dcount + 32'd1;
      if (abort_err && errcount != ERRCOUNT_MAX) errcount <= errcount + 16'd1;
    end
  end

  // A simultaneous read and write request is serviced as a write but is a cache bug.
  a_no_rd_wr: assert property (@(posedge CLK) disable iff (RST) !(bus.dREN && bus.dWEN))
    else $error("mem_arbiter: dREN and dWEN asserted together");

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle table for the basic grant paths,
// then hand-written sequences against a small latency-2 RAM model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int RAM_LAT = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  word_t       icount, dcount;
  logic [15:0] errcount;

  mem_arbiter_if bus ();

  mem_arbiter #(.MAX_DSTREAK(4), .TIMEOUT_CYCLES(8)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus),
    .icount   (icount),
    .dcount   (dcount),
    .errcount (errcount)
  );

  always #5 CLK = ~CLK;

  // RAM model: ACCESS on the RAM_LAT-th cycle after the first enabled cycle.
  logic      ram_auto = 1'b0;
  logic      ram_hang = 1'b0;
  logic      err_once = 1'b0;
  ramstate_t tb_rs    = FREE;
  word_t     tb_rload = '0;
  ramstate_t model_rs;
  word_t     model_load;
  logic [7:0] ram_cnt = '0;

  always @(posedge CLK) ram_cnt <= (bus.ramREN | bus.ramWEN) ? ram_cnt + 8'd1 : 8'd0;

  always_comb begin
    model_rs   = FREE;
    model_load = bus.ramaddr ^ 32'hA5A5_0000;
    if (bus.ramREN | bus.ramWEN) begin
      if (ram_hang)                 model_rs = BUSY;
      else if (ram_cnt == RAM_LAT)  model_rs = err_once ? ERROR : ACCESS;
      else                          model_rs = BUSY;
    end
  end

  assign bus.ramstate = ram_auto ? model_rs   : tb_rs;
  assign bus.ramload  = ram_auto ? model_load : tb_rload;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic      iren;  word_t iaddr;
    logic      dren;  word_t daddr;
    ramstate_t rs;    word_t rload;
    logic      e_iwait; logic e_dwait; logic e_ramren;
    word_t     e_ramaddr; word_t e_iload; word_t e_dload;
  } vec_t;

  function automatic vec_t mk(logic iren, word_t iaddr, logic dren, word_t daddr,
                              ramstate_t rs, word_t rload, logic iw, logic dw,
                              logic rr, word_t ra, word_t il, word_t dl);
    vec_t v;
    v.iren = iren; v.iaddr = iaddr; v.dren = dren; v.daddr = daddr;
    v.rs = rs; v.rload = rload; v.e_iwait = iw; v.e_dwait = dw;
    v.e_ramren = rr; v.e_ramaddr = ra; v.e_iload = il; v.e_dload = dl;
    return v;
  endfunction

  vec_t vecs[14];
  byte  ev[7];
  int   nev, dn, gcnt;
  logic i_seen, iw_low, saw_err, done, seen_grant;

  initial begin
    bus.iREN = 0; bus.iaddr = '0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = '0; bus.dstore = '0;

    // Reset state.
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_iwait", 32'(bus.iwait), 32'd1);
    check("rst_dwait", 32'(bus.dwait), 32'd1);
    check("rst_ramren", 32'(bus.ramREN), 32'd0);
    check("rst_ramwen", 32'(bus.ramWEN), 32'd0);
    check("rst_ramaddr", bus.ramaddr, 32'd0);
    check("rst_icount", icount, 32'd0);
    check("rst_errcount", 32'(errcount), 32'd0);

    // Test 1 (icache alone, latency 3) and test 2 (dcache first, icache after IDLE).
    vecs[0]  = mk(1, 32'h40, 0, 0,     FREE,   0,            1, 1, 0, 0,     0, 0);
    vecs[1]  = mk(1, 32'h40, 0, 0,     BUSY,   0,            1, 1, 1, 32'h40, 0, 0);
    vecs[2]  = mk(1, 32'h40, 0, 0,     BUSY,   0,            1, 1, 1, 32'h40, 0, 0);
    vecs[3]  = mk(1, 32'h40, 0, 0,     ACCESS, 32'h12345678, 0, 1, 1, 32'h40, 32'h12345678, 0);
    vecs[4]  = mk(0, 0,      0, 0,     FREE,   0,            1, 1, 0, 0,     0, 0);
    vecs[5]  = mk(1, 32'h44, 1, 32'h80, FREE,  0,            1, 1, 0, 0,     0, 0);
    vecs[6]  = mk(1, 32'h44, 1, 32'h80, BUSY,  0,            1, 1, 1, 32'h80, 0, 0);
    vecs[7]  = mk(1, 32'h44, 1, 32'h80, BUSY,  0,            1, 1, 1, 32'h80, 0, 0);
    vecs[8]  = mk(1, 32'h44, 1, 32'h80, ACCESS, 32'hAAAA5555, 1, 0, 1, 32'h80, 0, 32'hAAAA5555);
    vecs[9]  = mk(1, 32'h44, 0, 0,     FREE,   0,            1, 1, 0, 0,     0, 0);
    vecs[10] = mk(1, 32'h44, 0, 0,     BUSY,   0,            1, 1, 1, 32'h44, 0, 0);
    vecs[11] = mk(1, 32'h44, 0, 0,     BUSY,   0,            1, 1, 1, 32'h44, 0, 0);
    vecs[12] = mk(1, 32'h44, 0, 0,     ACCESS, 32'h0BADF00D, 0, 1, 1, 32'h44, 32'h0BADF00D, 0);
    vecs[13] = mk(0, 0,      0, 0,     FREE,   0,            1, 1, 0, 0,     0, 0);

    for (int i = 0; i < 14; i++) begin
      @(posedge CLK);
      #1;
      bus.iREN = vecs[i].iren; bus.iaddr = vecs[i].iaddr;
      bus.dREN = vecs[i].dren; bus.daddr = vecs[i].daddr;
      tb_rs = vecs[i].rs; tb_rload = vecs[i].rload;
      @(negedge CLK);
      check($sformatf("v%0d_iwait", i),   32'(bus.iwait),  32'(vecs[i].e_iwait));
      check($sformatf("v%0d_dwait", i),   32'(bus.dwait),  32'(vecs[i].e_dwait));
      check($sformatf("v%0d_ramren", i),  32'(bus.ramREN), 32'(vecs[i].e_ramren));
      check($sformatf("v%0d_ramaddr", i), bus.ramaddr,     vecs[i].e_ramaddr);
      check($sformatf("v%0d_iload", i),   bus.iload,       vecs[i].e_iload);
      check($sformatf("v%0d_dload", i),   bus.dload,       vecs[i].e_dload);
    end
    check("t12_icount", icount, 32'd2);
    check("t12_dcount", dcount, 32'd1);

    // Test 3: icache held, six back-to-back dcache reads -> D D D D I D D.
    tb_rs = FREE; tb_rload = '0;
    ram_auto = 1'b1;
    @(posedge CLK);
    #1;
    bus.iREN = 1; bus.iaddr = 32'h100; bus.dREN = 1; bus.daddr = 32'h200;
    nev = 0; dn = 0; i_seen = 0;
    for (int c = 0; c < 300 && nev < 7; c++) begin
      @(negedge CLK);
      if (!bus.dwait) begin ev[nev] = "D"; nev++; dn++; end
      if (!bus.iwait) begin ev[nev] = "I"; nev++; i_seen = 1; end
      @(posedge CLK);
      #1;
      if (dn >= 6) bus.dREN = 0;
      if (i_seen)  bus.iREN = 0;
    end
    check("t3_events", 32'(nev), 32'd7);
    for (int k = 0; k < 7; k++)
      check($sformatf("t3_ev%0d", k), 32'(ev[k]), (k == 4) ? 32'("I") : 32'("D"));
    check("t3_icount", icount, 32'd3);
    check("t3_dcount", dcount, 32'd7);
    bus.iREN = 0; bus.dREN = 0;
    @(posedge CLK);

    // Test 4: write hits one RAM ERROR, then completes on retry.
    #1;
    err_once = 1; bus.dWEN = 1; bus.daddr = 32'h3100; bus.dstore = 32'hDEADBEEF;
    saw_err = 0; done = 0; seen_grant = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge CLK);
      if (bus.ramWEN && !seen_grant) begin
        seen_grant = 1;
        check("t4_ramren", 32'(bus.ramREN), 32'd0);
        check("t4_ramaddr", bus.ramaddr, 32'h3100);
        check("t4_ramstore", bus.ramstore, 32'hDEADBEEF);
      end
      if (bus.ramstate == ERROR) begin
        saw_err = 1;
        check("t4_dwait_on_err", 32'(bus.dwait), 32'd1);
      end
      if (!bus.dwait) begin
        done = 1;
        check("t4_dload_write", bus.dload, 32'd0);
      end else begin
        @(posedge CLK);
        #1;
        if (saw_err) err_once = 0;
      end
    end
    check("t4_done", 32'(done), 32'd1);
    check("t4_saw_err", 32'(saw_err), 32'd1);
    @(posedge CLK);
    #1;
    bus.dWEN = 0; err_once = 0;
    check("t4_errcount", 32'(errcount), 32'd1);
    check("t4_dcount", dcount, 32'd8);

    // Test 5: RAM hangs; grant aborts after 8 cycles and is re-issued.
    ram_hang = 1; bus.iREN = 1; bus.iaddr = 32'h200;
    gcnt = 0; iw_low = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (!bus.iwait) iw_low = 1;
      if (bus.ramREN) gcnt++;
      else if (gcnt > 0) break;
      @(posedge CLK);
      #1;
    end
    check("t5_grant_cycles", 32'(gcnt), 32'd8);
    check("t5_errcount", 32'(errcount), 32'd2);
    done = 0;
    for (int c = 0; c < 5 && !done; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (!bus.iwait) iw_low = 1;
      if (bus.ramREN) done = 1;
    end
    check("t5_regrant", 32'(done), 32'd1);
    check("t5_iwait_high", 32'(iw_low), 32'd0);

    // Test 6: one-cycle reset in mid-grant.
    @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("t6_ramren", 32'(bus.ramREN), 32'd0);
    check("t6_iwait", 32'(bus.iwait), 32'd1);
    check("t6_dwait", 32'(bus.dwait), 32'd1);
    check("t6_icount", icount, 32'd0);
    check("t6_dcount", dcount, 32'd0);
    check("t6_errcount", 32'(errcount), 32'd0);
    bus.iREN = 0; ram_hang = 0;
    repeat (2) @(posedge CLK);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_mem_arbiter
